// File: rtl/bp_be_pkg.sv
`default_nettype none
// ============================================================================
// Module     : bp_be_pkg
// Purpose    : Shared types and constants for the BE dependency tracker.
//              The dependency-pipe entry type depends on the register address
//              width and the FU-class width. A package cannot take parameters,
//              so the struct is declared through a macro that is expanded
//              inside each user module.
// Ports      : none (package)
// Revision   : 1.0 - initial release
// ============================================================================

`ifndef BP_BE_PKG_SV
`define BP_BE_PKG_SV

// Declares bp_be_dep_entry_s in the enclosing scope: {v, fu, rd_addr}
`define BP_BE_DEP_ENTRY_DECLARE(addr_width_mp, fu_width_mp) \
    typedef struct packed {                                 \
        logic                     v;                        \
        logic [fu_width_mp-1:0]   fu;                       \
        logic [addr_width_mp-1:0] rd_addr;                  \
    } bp_be_dep_entry_s;

package bp_be_pkg;

    // Width of one per-FU ready-stage field
    localparam int dep_ready_stage_width_gp = 4;

    // Default per-FU forwarding stage, FU0 in the LSBs
    localparam logic [15:0] dep_fu_ready_stage_default_gp = {4'd0, 4'd3, 4'd2, 4'd1};

    // FU-class index width; never zero so that one-FU configs stay legal
    function automatic int fu_width_f(input int num_fu);
        return (num_fu > 1) ? $clog2(num_fu) : 1;
    endfunction

endpackage

`endif
`default_nettype wire

// File: rtl/bp_be_scoreboard_cnt.sv
`default_nettype none
// ============================================================================
// Module     : bp_be_scoreboard_cnt
// Purpose    : Per-register outstanding late-write counters. Each score
//              increments and each clear decrements the addressed counter. A
//              score and a clear to the same address in one cycle cancel.
//              The counters expose num_lookup_p read ports that report a
//              nonzero count, and a saturation flag on the last port, which
//              carries the destination address.
// Ports      : clk_i, reset_i           - clock, sync active-high reset
//              score_v_i/score_addr_i   - increment request
//              clear_v_i/clear_addr_i   - decrement request
//              lookup_addr_i            - packed lookup addresses, port 0 in LSBs
//              lookup_busy_o            - counter[addr] != 0 per port
//              rd_full_o                - last port's counter is saturated
// Revision   : 1.0 - initial release
// ============================================================================
module bp_be_scoreboard_cnt
    import bp_be_pkg::*;
#(
    parameter int reg_addr_width_p     = 5,
    parameter int num_lookup_p         = 4,
    parameter int cnt_width_p          = 2,
    parameter int zero_reg_hardwired_p = 1
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   score_v_i,
    input  logic [reg_addr_width_p-1:0]            score_addr_i,
    input  logic                                   clear_v_i,
    input  logic [reg_addr_width_p-1:0]            clear_addr_i,
    input  logic [num_lookup_p*reg_addr_width_p-1:0] lookup_addr_i,
    output logic [num_lookup_p-1:0]                lookup_busy_o,
    output logic                                   rd_full_o
);

    localparam int                     num_regs_lp = 1 << reg_addr_width_p;
    localparam logic [cnt_width_p-1:0] cnt_max_lp  = '1;

    logic [num_regs_lp*cnt_width_p-1:0] cnt_flat;
    logic                               score_en;
    logic                               clear_en;
    logic                               same_addr;

    // With a hardwired zero register, x0 is never scored or cleared
    assign score_en  = score_v_i & ~((zero_reg_hardwired_p != 0) && (score_addr_i == '0));
    assign clear_en  = clear_v_i & ~((zero_reg_hardwired_p != 0) && (clear_addr_i == '0));
    assign same_addr = score_en & clear_en & (score_addr_i == clear_addr_i);

    for (genvar r = 0; r < num_regs_lp; r++) begin : g_cnt
        logic [cnt_width_p-1:0] cnt;
        logic                   inc;
        logic                   dec;

        // Saturated score and empty clear are dropped (and flagged below)
        assign inc = score_en & ~same_addr & (score_addr_i == reg_addr_width_p'(r))
                   & (cnt != cnt_max_lp);
        assign dec = clear_en & ~same_addr & (clear_addr_i == reg_addr_width_p'(r))
                   & (cnt != '0);

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                cnt <= '0;
            end else if (inc) begin
                cnt <= cnt + 1'b1;
            end else if (dec) begin
                cnt <= cnt - 1'b1;
            end
        end

        assign cnt_flat[r*cnt_width_p +: cnt_width_p] = cnt;
    end

    for (genvar p = 0; p < num_lookup_p; p++) begin : g_lookup
        logic [reg_addr_width_p-1:0] addr;
        assign addr             = lookup_addr_i[p*reg_addr_width_p +: reg_addr_width_p];
        assign lookup_busy_o[p] = (cnt_flat[int'(addr)*cnt_width_p +: cnt_width_p] != '0);
    end

    logic [reg_addr_width_p-1:0] rd_lookup_addr;
    assign rd_lookup_addr = lookup_addr_i[(num_lookup_p-1)*reg_addr_width_p +: reg_addr_width_p];
    assign rd_full_o      = (cnt_flat[int'(rd_lookup_addr)*cnt_width_p +: cnt_width_p] == cnt_max_lp);

    logic [cnt_width_p-1:0] score_cnt;
    logic [cnt_width_p-1:0] clear_cnt;
    assign score_cnt = cnt_flat[int'(score_addr_i)*cnt_width_p +: cnt_width_p];
    assign clear_cnt = cnt_flat[int'(clear_addr_i)*cnt_width_p +: cnt_width_p];

    a_no_clear_empty: assert property (@(posedge clk_i) disable iff (reset_i)
        !(clear_en && !same_addr && (clear_cnt == '0)));
    a_no_score_full: assert property (@(posedge clk_i) disable iff (reset_i)
        !(score_en && !same_addr && (score_cnt == cnt_max_lp)));

endmodule
`default_nettype wire

// File: rtl/bp_be_dep_tracker.sv
`default_nettype none
// ============================================================================
// Module     : bp_be_dep_tracker
// Purpose    : Dependency tracker for one register class.
//              - A depth_p-stage pipe of in-flight destinations, with
//                per-FU forwarding readiness.
//              - A late-writeback scoreboard.
//              - Flush of the youngest stages.
//              - A saturating stall counter.
//              All hazard outputs are combinational from the issue inputs
//              and the current state.
// Ports      : clk_i/reset_i           - clock, sync active-high reset
//              issue_*                 - instruction in ISD (sources, dest)
//              dispatch_*              - instruction entering EX1
//              score_*/clear_*         - late writeback score / completion
//              flush_i                 - kill youngest flush_depth_p stages
//              stall_cnt_clr_i         - clear stall counter
//              raw_haz_o/waw_haz_o/sb_full_o/haz_o - hazard outputs
//              stall_cnt_o             - saturating stalled-issue count
// Revision   : 1.0 - initial release
// ============================================================================
module bp_be_dep_tracker
    import bp_be_pkg::*;
#(
    parameter int                    reg_addr_width_p     = 5,
    parameter int                    num_rs_p             = 3,
    parameter int                    depth_p              = 4,
    parameter int                    num_fu_p             = 4,
    parameter logic [num_fu_p*4-1:0] fu_ready_stage_p     = dep_fu_ready_stage_default_gp,
    parameter int                    zero_reg_hardwired_p = 1,
    parameter int                    sb_cnt_width_p       = 2,
    parameter int                    flush_depth_p        = 2,
    parameter int                    stall_cnt_width_p    = 16,
    localparam int                   fu_width_lp          = fu_width_f(num_fu_p)
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 issue_v_i,
    input  logic [num_rs_p-1:0]                  issue_rs_v_i,
    input  logic [num_rs_p*reg_addr_width_p-1:0] issue_rs_addr_i,
    input  logic                                 issue_rd_v_i,
    input  logic [reg_addr_width_p-1:0]          issue_rd_addr_i,
    input  logic                                 dispatch_v_i,
    input  logic [fu_width_lp-1:0]               dispatch_fu_i,
    input  logic                                 dispatch_rd_w_v_i,
    input  logic [reg_addr_width_p-1:0]          dispatch_rd_addr_i,
    input  logic                                 dispatch_late_i,
    input  logic                                 score_v_i,
    input  logic [reg_addr_width_p-1:0]          score_rd_i,
    input  logic                                 clear_v_i,
    input  logic [reg_addr_width_p-1:0]          clear_rd_i,
    input  logic                                 flush_i,
    input  logic                                 stall_cnt_clr_i,
    output logic [num_rs_p-1:0]                  raw_haz_o,
    output logic                                 waw_haz_o,
    output logic                                 sb_full_o,
    output logic                                 haz_o,
    output logic [stall_cnt_width_p-1:0]         stall_cnt_o
);

    `BP_BE_DEP_ENTRY_DECLARE(reg_addr_width_p, fu_width_lp)

    bp_be_dep_entry_s [depth_p-1:0] stage_r;
    bp_be_dep_entry_s [depth_p-1:0] stage_n;
    bp_be_dep_entry_s               dispatch_entry;

    // First stage from which an FU's result can be forwarded
    function automatic int ready_stage(input logic [fu_width_lp-1:0] fu);
        if (int'(fu) >= num_fu_p) begin
            return 0;
        end
        return int'(fu_ready_stage_p[int'(fu)*dep_ready_stage_width_gp +: dep_ready_stage_width_gp]);
    endfunction

    function automatic logic is_zero_masked(input logic [reg_addr_width_p-1:0] addr);
        return (zero_reg_hardwired_p != 0) && (addr == '0);
    endfunction

    // ---------------- Pipe ----------------
    // Late writebacks go to the scoreboard instead of the pipe
    always_comb begin
        dispatch_entry.v       = dispatch_v_i & dispatch_rd_w_v_i & ~dispatch_late_i
                               & ~is_zero_masked(dispatch_rd_addr_i);
        dispatch_entry.fu      = dispatch_fu_i;
        dispatch_entry.rd_addr = dispatch_rd_addr_i;
    end

    // On a flush, stages 0..flush_depth_p-1 are killed. Stage flush_depth_p
    // would receive a killed entry, so it ends up empty as well; that also
    // covers the discarded dispatch when flush_depth_p is 0.
    always_comb begin
        stage_n[0] = dispatch_entry;
        for (int i = 1; i < depth_p; i++) begin
            stage_n[i] = stage_r[i-1];
        end
        if (flush_i) begin
            for (int i = 0; i < depth_p; i++) begin
                if (i <= flush_depth_p) begin
                    stage_n[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stage_r <= '0;
        end else begin
            stage_r <= stage_n;
        end
    end

    // ---------------- Scoreboard ----------------
    logic                                     late_disp;
    logic                                     late_score;
    logic                                     sb_score_v;
    logic [reg_addr_width_p-1:0]              sb_score_addr;
    logic [(num_rs_p+1)*reg_addr_width_p-1:0] sb_lookup_addr;
    logic [num_rs_p:0]                        sb_busy;
    logic                                     sb_rd_full;

    assign late_disp     = dispatch_v_i & dispatch_rd_w_v_i & dispatch_late_i;
    assign late_score    = late_disp & ~flush_i;
    assign sb_score_v    = late_score | score_v_i;
    assign sb_score_addr = late_score ? dispatch_rd_addr_i : score_rd_i;
    // The destination goes on the last lookup port
    assign sb_lookup_addr = {issue_rd_addr_i, issue_rs_addr_i};

    bp_be_scoreboard_cnt #(
        .reg_addr_width_p     (reg_addr_width_p),
        .num_lookup_p         (num_rs_p + 1),
        .cnt_width_p          (sb_cnt_width_p),
        .zero_reg_hardwired_p (zero_reg_hardwired_p)
    ) u_sb (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .score_v_i     (sb_score_v),
        .score_addr_i  (sb_score_addr),
        .clear_v_i     (clear_v_i),
        .clear_addr_i  (clear_rd_i),
        .lookup_addr_i (sb_lookup_addr),
        .lookup_busy_o (sb_busy),
        .rd_full_o     (sb_rd_full)
    );

    a_one_score_source: assert property (@(posedge clk_i) disable iff (reset_i)
        !(late_disp && score_v_i));

    // ---------------- Hazards ----------------
    always_comb begin
        raw_haz_o = '0;
        for (int j = 0; j < num_rs_p; j++) begin
            logic [reg_addr_width_p-1:0] rs;
            logic                        pipe_hit;
            rs       = issue_rs_addr_i[j*reg_addr_width_p +: reg_addr_width_p];
            pipe_hit = 1'b0;
            for (int s = 0; s < depth_p; s++) begin
                if (stage_r[s].v && (stage_r[s].rd_addr == rs)
                    && (s < ready_stage(stage_r[s].fu))) begin
                    pipe_hit = 1'b1;
                end
            end
            raw_haz_o[j] = issue_v_i & issue_rs_v_i[j] & ~is_zero_masked(rs)
                         & (pipe_hit | sb_busy[j]);
        end
    end

    logic rd_chk;
    assign rd_chk    = issue_v_i & issue_rd_v_i & ~is_zero_masked(issue_rd_addr_i);
    assign waw_haz_o = rd_chk & sb_busy[num_rs_p];
    assign sb_full_o = rd_chk & sb_rd_full;
    assign haz_o     = (|raw_haz_o) | waw_haz_o | sb_full_o;

    // ---------------- Stall counter ----------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_o <= '0;
        end else if (stall_cnt_clr_i) begin
            stall_cnt_o <= '0;
        end else if (issue_v_i && haz_o && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bp_be_dep_tracker.sv
`default_nettype none
// ============================================================================
// Module     : tb_bp_be_dep_tracker
// Purpose    : Directed scoreboard bench for bp_be_dep_tracker.
//              Instance "a" uses a hardwired zero register and a 4-bit stall
//              counter. Instance "b" is an fp-style instance in which x0 is a
//              real register. Both receive the same stimulus.
//              FU ready stages: FU0=1, FU1=2, FU2=3, FU3=4 (depth 4).
// Revision   : 1.0 - initial release
// ============================================================================
module tb_bp_be_dep_tracker;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        issue_v, issue_rd_v, disp_v, disp_w, disp_late;
    logic        score_v, clear_v, flush, stall_clr;
    logic [2:0]  issue_rs_v;
    logic [14:0] issue_rs_addr;
    logic [4:0]  issue_rd_addr, disp_rd, score_rd, clear_rd;
    logic [1:0]  disp_fu;

    logic [2:0]  raw_a, raw_b;
    logic        waw_a, full_a, haz_a, waw_b, full_b, haz_b;
    logic [3:0]  stall_a;
    logic [15:0] stall_b;

    always #5 clk = ~clk;

    bp_be_dep_tracker #(
        .fu_ready_stage_p     (16'h4321),
        .zero_reg_hardwired_p (1),
        .stall_cnt_width_p    (4)
    ) dut_a (
        .clk_i (clk), .reset_i (reset_i),
        .issue_v_i (issue_v), .issue_rs_v_i (issue_rs_v), .issue_rs_addr_i (issue_rs_addr),
        .issue_rd_v_i (issue_rd_v), .issue_rd_addr_i (issue_rd_addr),
        .dispatch_v_i (disp_v), .dispatch_fu_i (disp_fu), .dispatch_rd_w_v_i (disp_w),
        .dispatch_rd_addr_i (disp_rd), .dispatch_late_i (disp_late),
        .score_v_i (score_v), .score_rd_i (score_rd),
        .clear_v_i (clear_v), .clear_rd_i (clear_rd),
        .flush_i (flush), .stall_cnt_clr_i (stall_clr),
        .raw_haz_o (raw_a), .waw_haz_o (waw_a), .sb_full_o (full_a), .haz_o (haz_a),
        .stall_cnt_o (stall_a)
    );

    bp_be_dep_tracker #(
        .fu_ready_stage_p     (16'h4321),
        .zero_reg_hardwired_p (0),
        .stall_cnt_width_p    (16)
    ) dut_b (
        .clk_i (clk), .reset_i (reset_i),
        .issue_v_i (issue_v), .issue_rs_v_i (issue_rs_v), .issue_rs_addr_i (issue_rs_addr),
        .issue_rd_v_i (issue_rd_v), .issue_rd_addr_i (issue_rd_addr),
        .dispatch_v_i (disp_v), .dispatch_fu_i (disp_fu), .dispatch_rd_w_v_i (disp_w),
        .dispatch_rd_addr_i (disp_rd), .dispatch_late_i (disp_late),
        .score_v_i (score_v), .score_rd_i (score_rd),
        .clear_v_i (clear_v), .clear_rd_i (clear_rd),
        .flush_i (flush), .stall_cnt_clr_i (stall_clr),
        .raw_haz_o (raw_b), .waw_haz_o (waw_b), .sb_full_o (full_b), .haz_o (haz_b),
        .stall_cnt_o (stall_b)
    );

    typedef struct {
        string      name;
        logic [2:0] raw;
        logic       waw;
        logic       full;
        logic       haz;
        logic [3:0] stall;
        logic [2:0] raw_b;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Monitor: every expectation queued for this cycle is checked on the falling edge
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic hb;
            e  = exp_q.pop_front();
            hb = (|e.raw_b) | e.waw | e.full;
            n_cmp++;
            if (raw_a !== e.raw || waw_a !== e.waw || full_a !== e.full || haz_a !== e.haz
                || stall_a !== e.stall || raw_b !== e.raw_b || haz_b !== hb) begin
                n_bad++;
                $display("FAIL %s: got raw=%b waw=%b full=%b haz=%b stall=%0d raw_b=%b haz_b=%b, want raw=%b waw=%b full=%b haz=%b stall=%0d raw_b=%b haz_b=%b",
                         e.name, raw_a, waw_a, full_a, haz_a, stall_a, raw_b, haz_b,
                         e.raw, e.waw, e.full, e.haz, e.stall, e.raw_b, hb);
            end
        end
    end

    task automatic idle();
        issue_v = 0; issue_rs_v = '0; issue_rs_addr = '0; issue_rd_v = 0; issue_rd_addr = '0;
        disp_v = 0; disp_fu = '0; disp_w = 0; disp_rd = '0; disp_late = 0;
        score_v = 0; score_rd = '0; clear_v = 0; clear_rd = '0;
        flush = 0; stall_clr = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
        idle();
    endtask

    task automatic chk(input string nm, input logic [2:0] raw, input logic waw,
                       input logic full, input logic haz, input logic [3:0] stall,
                       input logic [2:0] rb);
        exp_t e;
        e.name = nm; e.raw = raw; e.waw = waw; e.full = full; e.haz = haz;
        e.stall = stall; e.raw_b = rb;
        exp_q.push_back(e);
    endtask

    task automatic dispatch(input logic [1:0] fu, input logic [4:0] rd, input logic late);
        disp_v = 1; disp_w = 1; disp_fu = fu; disp_rd = rd; disp_late = late;
    endtask

    task automatic issue_rs(input logic [2:0] v, input logic [4:0] a3, input logic [4:0] a2,
                            input logic [4:0] a1);
        issue_v = 1; issue_rs_v = v; issue_rs_addr = {a3, a2, a1};
    endtask

    task automatic issue_rd(input logic [4:0] a);
        issue_v = 1; issue_rd_v = 1; issue_rd_addr = a;
    endtask

    task automatic score(input logic [4:0] a);
        score_v = 1; score_rd = a;
    endtask

    task automatic clear(input logic [4:0] a);
        clear_v = 1; clear_rd = a;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset_i = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        reset_i = 0;
        issue_rs(3'b111, 5'd3, 5'd2, 5'd1); issue_rd(5'd1);
        chk("post_reset", 0, 0, 0, 0, 0, 0);
        tick();

        // FU2 (ready stage 3) writes x7: hazard at EX1..EX3, clear at EX4
        dispatch(2'd2, 5'd7, 0);
        chk("pipe_disp", 0, 0, 0, 0, 0, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            issue_rs(3'b001, 5'd0, 5'd0, 5'd7);
            if (k < 3) chk("pipe_raw", 3'b001, 0, 0, 1, 4'(k), 3'b001);
            else       chk("pipe_ex4", 3'b000, 0, 0, 0, 4'd3, 3'b000);
            tick();
        end
        chk("pipe_stall3", 0, 0, 0, 0, 3, 0);
        tick();

        // x0: masked in a, a real register in b
        dispatch(2'd2, 5'd0, 0);
        chk("zero_disp", 0, 0, 0, 0, 3, 0);
        tick();
        issue_rs(3'b001, 5'd0, 5'd0, 5'd0);
        chk("zero_raw", 0, 0, 0, 0, 3, 3'b001);
        tick();
        repeat (4) tick();

        // Late writeback scoreboard on x5
        dispatch(2'd0, 5'd5, 1); stall_clr = 1;
        chk("late1", 0, 0, 0, 0, 3, 0);
        tick();
        dispatch(2'd0, 5'd5, 1);
        chk("late2", 0, 0, 0, 0, 0, 0);
        tick();
        clear(5'd5); issue_rd(5'd5); issue_rs(3'b001, 5'd0, 5'd0, 5'd5);
        chk("waw_cnt2", 3'b001, 1, 0, 1, 0, 3'b001);
        tick();
        issue_rd(5'd5); issue_rs(3'b001, 5'd0, 5'd0, 5'd5);
        chk("waw_cnt1", 3'b001, 1, 0, 1, 1, 3'b001);
        tick();
        clear(5'd5); issue_rd(5'd5); issue_rs(3'b001, 5'd0, 5'd0, 5'd5);
        chk("waw_clr_cycle", 3'b001, 1, 0, 1, 2, 3'b001);
        tick();
        issue_rd(5'd5); issue_rs(3'b001, 5'd0, 5'd0, 5'd5);
        chk("waw_gone", 0, 0, 0, 0, 3, 0);
        tick();
        score(5'd5);
        tick();
        score(5'd5); clear(5'd5); issue_rd(5'd5); issue_rs(3'b001, 5'd0, 5'd0, 5'd5);
        chk("score_clear_same", 3'b001, 1, 0, 1, 3, 3'b001);
        tick();
        issue_rd(5'd5); issue_rs(3'b001, 5'd0, 5'd0, 5'd5);
        chk("score_clear_hold", 3'b001, 1, 0, 1, 4, 3'b001);
        tick();
        clear(5'd5);
        tick();
        issue_rd(5'd5); issue_rs(3'b001, 5'd0, 5'd0, 5'd5);
        chk("score_clear_empty", 0, 0, 0, 0, 5, 0);
        tick();

        // Saturate x9 (2-bit counter, max 3)
        repeat (3) begin
            score(5'd9);
            tick();
        end
        issue_rd_v = 1; issue_rd_addr = 5'd9;
        chk("full_no_issue", 0, 0, 0, 0, 5, 0);
        tick();
        issue_rd(5'd9);
        chk("sb_full", 0, 1, 1, 1, 5, 0);
        tick();
        clear(5'd9); score(5'd10);
        tick();
        issue_rd(5'd9); issue_rs(3'b001, 5'd0, 5'd0, 5'd10);
        chk("indep_addr", 3'b001, 1, 0, 1, 6, 3'b001);
        tick();
        clear(5'd9); tick();
        clear(5'd9); tick();
        clear(5'd10); tick();
        issue_rd(5'd9); issue_rs(3'b001, 5'd0, 5'd0, 5'd10);
        chk("sb_drained", 0, 0, 0, 0, 7, 0);
        tick();

        // Flush: x11 by FU3 (ready 4) reaches EX3, x3 by FU2 sits in EX1
        dispatch(2'd3, 5'd11, 0); stall_clr = 1;
        chk("flush_d0", 0, 0, 0, 0, 7, 0);
        tick();
        tick();
        dispatch(2'd2, 5'd3, 0);
        tick();
        issue_rs(3'b111, 5'd4, 5'd11, 5'd3); flush = 1; dispatch(2'd2, 5'd4, 0);
        chk("flush_pre", 3'b011, 0, 0, 1, 0, 3'b011);
        tick();
        issue_rs(3'b111, 5'd4, 5'd11, 5'd3);
        chk("flush_post", 3'b010, 0, 0, 1, 1, 3'b010);
        tick();
        issue_rs(3'b111, 5'd4, 5'd11, 5'd3);
        chk("flush_drain", 0, 0, 0, 0, 2, 0);
        tick();
        flush = 1; dispatch(2'd0, 5'd12, 1);
        tick();
        flush = 1; score(5'd13);
        tick();
        issue_rd(5'd12);
        chk("flush_late_drop", 0, 0, 0, 0, 2, 0);
        tick();
        issue_rd(5'd13);
        chk("flush_score_kept", 0, 1, 0, 1, 2, 0);
        tick();
        clear(5'd13);
        tick();

        // Stall counter saturation and clear priority (4-bit counter)
        score(5'd20); stall_clr = 1;
        tick();
        repeat (15) begin
            issue_rd(5'd20);
            tick();
        end
        issue_rd(5'd20);
        chk("stall_sat", 0, 1, 0, 1, 15, 0);
        tick();
        issue_rd(5'd20);
        chk("stall_sat_hold", 0, 1, 0, 1, 15, 0);
        tick();
        issue_rd(5'd20); stall_clr = 1;
        chk("stall_clr_pri", 0, 1, 0, 1, 15, 0);
        tick();
        issue_rd(5'd20); dispatch(2'd3, 5'd21, 0);
        chk("stall_cleared", 0, 1, 0, 1, 0, 0);
        tick();

        // Reset mid-stream drops the pipe entry, scoreboard and stall count
        issue_rd(5'd20); issue_rs(3'b001, 5'd0, 5'd0, 5'd21); reset_i = 1;
        chk("pre_reset", 3'b001, 1, 0, 1, 1, 3'b001);
        tick();
        reset_i = 0;
        issue_rd(5'd20); issue_rs(3'b001, 5'd0, 5'd0, 5'd21);
        chk("mid_reset", 0, 0, 0, 0, 0, 0);
        tick();

        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
